fc_score_serializer: RTL and testbench
======================================

Name: fc_score_serializer

Overview:
- Producer end of the class-score stream feeding the final decision comparator.
- Collects NUM_CLASS fully-connected accumulator results, quantizes and saturates each to 12-bit two's complement, and stores them in a ping-pong buffer.
- Emits each committed frame as one contiguous valid_out burst of NUM_CLASS cycles, class 0 first, then holds a mandatory idle gap.
- The gap gives the downstream decision logic time to resolve before the next burst.

Parameters:
- NUM_CLASS, 10, scores per frame; wr_idx is 4 bits, so NUM_CLASS ≤ 16.
- ACC_W, 20, width of the signed accumulator input.
- SHIFT, 4, arithmetic right shift applied before saturation.
- GAP_CYCLES, 8, idle cycles forced after each burst (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  score write strobe.
- wr_idx  in  4  class index of the write.
- wr_data  in  ACC_W  signed accumulator value.
- commit  in  1  fill bank complete, queue it for transmission.
- in_ready  out  1  fill bank can accept wr_en/commit.
- valid_out  out  1  score valid, high for NUM_CLASS consecutive cycles per frame.
- data_out  out  12  signed score; 0 when valid_out low.
- ovf_flag  out  1  high during a burst if any score in that frame saturated.
- busy  out  1  frame pending or transmission/gap in progress.

Behaviour:
- Single clock domain. One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset clears all outputs to 0, both banks, both full flags, fill-bank and tx-bank pointers (bank 0), and the FSM (IDLE). in_ready is 1 after reset.
- Quantization is applied at write: q = wr_data >>> SHIFT (sign-preserving).
  - If q > 2047, store 2047; if q < -2048, store -2048; set that entry's sat bit.
  - Otherwise store q[11:0] and clear the sat bit.
- Write: on wr_en && in_ready && wr_idx < NUM_CLASS, entry wr_idx of the fill bank is updated.
  - wr_idx ≥ NUM_CLASS: ignored.
  - wr_en while in_ready=0: dropped.
  - Unwritten entries keep their previous contents.
- Commit: on commit && in_ready, full[fill] is set and the fill pointer toggles. A same-cycle wr_en lands in the old bank before it is committed.
- in_ready = !full[fill], computed from registered state. A bank freed by TX is usable from the next cycle.
- TX FSM (states IDLE, SEND, GAP):
  - IDLE: if full[tb], go to SEND with idx=0.
  - SEND: registered valid_out=1, data_out=bank[tb][idx], ovf_flag = OR of bank[tb] sat bits. idx increments each cycle.
  - After idx = NUM_CLASS-1 is emitted: clear full[tb], toggle tb, go to GAP with counter 0.
  - GAP: valid_out=0, data_out=0 for GAP_CYCLES cycles, then IDLE.
- Latency: commit sampled at edge T with TX idle gives first valid_out at edge T+2. The burst is never interrupted or stalled; there is no backpressure from downstream.
- Back-to-back frames: the next burst starts exactly GAP_CYCLES+1 cycles after the previous last valid, i.e. GAP_CYCLES idle cycles plus one IDLE-state cycle.
- Both banks full: in_ready=0 until TX finishes the burst of tb.
- busy = (state != IDLE) | full[0] | full[1].
- Reset mid-burst: valid_out drops asynchronously and the frame is lost. The downstream comparator must share rst_n.

Optional Feature:
- Macro FC_SER_BIAS_EN.
- Defined:
  - Adds ports bias_we (in 1), bias_idx (in 4), bias_data (in 12 signed) and NUM_CLASS 12-bit bias registers, reset to 0.
  - On bias_we with bias_idx < NUM_CLASS, that class's bias register is loaded.
  - Each written score becomes sat12(sat12(q) + bias[wr_idx]), using a 13-bit intermediate.
  - Either saturation sets the sat bit.
  - Writing bias while the TX bank is in SEND does not affect stored scores.
- Undefined: no bias ports or registers; behaviour exactly as above.

Test Plan:
- Write wr_data = 16*k for k=0..9, then commit at cycle T -> valid_out high at T+2..T+11, data_out 0,1,..,9, ovf_flag=0, then GAP_CYCLES cycles of valid_out=0.
- Write 0x7FFFF to idx 3 and -0x80000 to idx 7 -> data_out[3]=2047, data_out[7]=-2048 (0x800), ovf_flag=1 for the whole burst.
- Commit three frames back-to-back -> in_ready=0 after the second commit until the first burst's last cycle+1; third commit then accepted; bursts separated by exactly GAP_CYCLES+1 idle cycles; no data mixing between frames.
- wr_idx=12 with data 0x00100 -> ignored, bank contents unchanged; wr_en while in_ready=0 -> dropped.
- Assert rst_n=0 at the 5th cycle of a burst -> valid_out, data_out, busy = 0 immediately; in_ready=1 after release; no residual burst.
- FC_SER_BIAS_EN: bias[2]=-5, score written 48 (q=3) -> data_out[2]=-2; bias[0]=2047 on q=2047 -> 2047, ovf_flag=1.

Source files
------------

// File: rtl/fc_score_serializer_if.sv
// Score-stream bundle for fc_score_serializer: producer write/commit side plus
// the outgoing class-score burst. The master drives writes; the slave is the serializer.
interface fc_score_serializer_if #(
  parameter int ACC_W = 20
);
  logic                    wr_en;
  logic [3:0]              wr_idx;
  logic signed [ACC_W-1:0] wr_data;
  logic                    commit;
  logic                    in_ready;
  logic                    valid_out;
  logic signed [11:0]      data_out;
  logic                    ovf_flag;
  logic                    busy;

  modport master (
    output wr_en, wr_idx, wr_data, commit,
    input  in_ready, valid_out, data_out, ovf_flag, busy
  );

  modport slave (
    input  wr_en, wr_idx, wr_data, commit,
    output in_ready, valid_out, data_out, ovf_flag, busy
  );
endinterface

// File: rtl/fc_score_serializer.sv
// Quantizes FC accumulator results into a ping-pong bank and emits each committed
// frame as a gapped NUM_CLASS-cycle burst. Optional per-class bias: FC_SER_BIAS_EN.
module fc_score_serializer #(
  parameter int NUM_CLASS  = 10,
  parameter int ACC_W      = 20,
  parameter int SHIFT      = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef FC_SER_BIAS_EN
  input  logic                bias_we,
  input  logic [3:0]          bias_idx,
  input  logic signed [11:0]  bias_data,
`endif
  fc_score_serializer_if.slave ser
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(2047);
  localparam logic signed [ACC_W-1:0] Q_MIN = ~Q_MAX;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e             state_q;
  logic [3:0]         idx_q;
  logic [GAP_W-1:0]   gap_q;
  logic               valid_q;
  logic [11:0]        data_q;
  logic               ovf_q;

  logic [11:0]          bank_q [2][NUM_CLASS];
  logic [11:0]          bank_d [2][NUM_CLASS];
  logic [NUM_CLASS-1:0] sat_q  [2];
  logic [NUM_CLASS-1:0] sat_d  [2];
  logic [1:0]           full_q, full_d;
  logic                 fill_q, fill_d;
  logic                 tb_q, tb_d;

  logic                    in_ready;
  logic                    wr_ok;
  logic                    commit_ok;
  logic                    tx_last;
  logic signed [ACC_W-1:0] q;
  logic [11:0]             q12;
  logic                    q_sat;
  logic [11:0]             wr_val;
  logic                    wr_sat;
  logic [11:0]             tx_word;
  logic                    tx_ovf;

  assign in_ready  = ~full_q[fill_q];
  assign wr_ok     = ser.wr_en & in_ready;
  assign commit_ok = ser.commit & in_ready;
  assign tx_last   = (state_q == SEND) && (idx_q == 4'(NUM_CLASS - 1));

  always_comb begin
    q = $signed(ser.wr_data) >>> SHIFT;
    if (q > Q_MAX) begin
      q12   = 12'h7FF;
      q_sat = 1'b1;
    end else if (q < Q_MIN) begin
      q12   = 12'h800;
      q_sat = 1'b1;
    end else begin
      q12   = q[11:0];
      q_sat = 1'b0;
    end
  end

`ifdef FC_SER_BIAS_EN
  logic [11:0] bias_q [NUM_CLASS];
  logic [11:0] bias_d [NUM_CLASS];
  logic [11:0] bias_sel;
  logic [12:0] sum13;

  always_comb begin
    bias_d = bias_q;
    if (bias_we) begin
      for (int unsigned c = 0; c < NUM_CLASS; c++) begin
        if (bias_idx == 4'(c)) bias_d[c] = bias_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CLASS; c++) bias_q[c] <= '0;
    end else begin
      bias_q <= bias_d;
    end
  end

  // Second saturation stage: 13-bit sum overflows when its top two bits differ.
  always_comb begin
    bias_sel = '0;
    for (int unsigned c = 0; c < NUM_CLASS; c++) begin
      if (ser.wr_idx == 4'(c)) bias_sel = bias_q[c];
    end
    sum13 = {q12[11], q12} + {bias_sel[11], bias_sel};
    if (sum13[12] != sum13[11]) begin
      wr_val = sum13[12] ? 12'h800 : 12'h7FF;
      wr_sat = 1'b1;
    end else begin
      wr_val = sum13[11:0];
      wr_sat = q_sat;
    end
  end
`else
  always_comb begin
    wr_val = q12;
    wr_sat = q_sat;
  end
`endif

  // A same-cycle write still targets the pre-commit fill bank.
  always_comb begin
    bank_d = bank_q;
    sat_d  = sat_q;
    full_d = full_q;
    fill_d = fill_q;
    tb_d   = tb_q;
    if (wr_ok) begin
      for (int unsigned c = 0; c < NUM_CLASS; c++) begin
        if (ser.wr_idx == 4'(c)) begin
          bank_d[fill_q][c] = wr_val;
          sat_d[fill_q][c]  = wr_sat;
        end
      end
    end
    if (tx_last) begin
      full_d[tb_q] = 1'b0;
      tb_d         = ~tb_q;
    end
    if (commit_ok) begin
      full_d[fill_q] = 1'b1;
      fill_d         = ~fill_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned c = 0; c < NUM_CLASS; c++) bank_q[b][c] <= '0;
        sat_q[b] <= '0;
      end
      full_q <= '0;
      fill_q <= 1'b0;
      tb_q   <= 1'b0;
    end else begin
      bank_q <= bank_d;
      sat_q  <= sat_d;
      full_q <= full_d;
      fill_q <= fill_d;
      tb_q   <= tb_d;
    end
  end

  always_comb begin
    tx_word = '0;
    for (int unsigned c = 0; c < NUM_CLASS; c++) begin
      if (idx_q == 4'(c)) tx_word = bank_q[tb_q][c];
    end
    tx_ovf = |sat_q[tb_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          data_q  <= '0;
          ovf_q   <= 1'b0;
          if (full_q[tb_q]) begin
            state_q <= SEND;
            idx_q   <= '0;
          end
        end
        SEND: begin
          valid_q <= 1'b1;
          data_q  <= tx_word;
          ovf_q   <= tx_ovf;
          if (tx_last) begin
            state_q <= GAP;
            idx_q   <= '0;
            gap_q   <= '0;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        GAP: begin
          valid_q <= 1'b0;
          data_q  <= '0;
          ovf_q   <= 1'b0;
          if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_q <= IDLE;
          else                                 gap_q   <= gap_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ser.in_ready  = in_ready;
  assign ser.valid_out = valid_q;
  assign ser.data_out  = data_q;
  assign ser.ovf_flag  = ovf_q;
  assign ser.busy      = (state_q != IDLE) | (|full_q);

endmodule

// File: tb/tb_fc_score_serializer.sv
// Directed bench for fc_score_serializer: latency, saturation, ping-pong
// back-to-back frames, dropped writes, mid-burst reset and (if enabled) bias.
module tb_fc_score_serializer;
  typedef logic [9:0][11:0] frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fc_score_serializer_if #(.ACC_W(20)) ser ();

`ifdef FC_SER_BIAS_EN
  logic        bias_we   = 1'b0;
  logic [3:0]  bias_idx  = '0;
  logic [11:0] bias_data = '0;
`endif

  fc_score_serializer #(
    .NUM_CLASS (10),
    .ACC_W     (20),
    .SHIFT     (4),
    .GAP_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef FC_SER_BIAS_EN
    .bias_we  (bias_we),
    .bias_idx (bias_idx),
    .bias_data(bias_data),
`endif
    .ser      (ser)
  );

  int n_checks = 0;
  int n_fail   = 0;

  frame_t fa, fs, fx, fy, fz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] idx, input logic [19:0] data);
    ser.wr_en   = 1'b1;
    ser.wr_idx  = idx;
    ser.wr_data = data;
    @(negedge clk);
    ser.wr_en   = 1'b0;
  endtask

  task automatic do_commit();
    ser.commit = 1'b1;
    @(negedge clk);
    ser.commit = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n = 0;
    while (ser.valid_out !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < max), 32'd1);
  endtask

  task automatic check_burst(input string tag, input frame_t e, input logic ovf, input bit rdy_low);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("%s_valid%0d", tag, i), 32'(ser.valid_out), 32'd1);
      check($sformatf("%s_data%0d", tag, i), {20'd0, ser.data_out}, {20'd0, e[i]});
      check($sformatf("%s_ovf%0d", tag, i), 32'(ser.ovf_flag), 32'(ovf));
      if (rdy_low && i >= 1 && i <= 8)
        check($sformatf("%s_rdy%0d", tag, i), 32'(ser.in_ready), 32'd0);
      @(negedge clk);
    end
    check({tag, "_end_valid"}, 32'(ser.valid_out), 32'd0);
  endtask

  task automatic count_idle(input string tag, input int exp_n);
    int n = 0;
    while (ser.valid_out !== 1'b1 && n < 40) begin
      if (ser.data_out !== 12'd0) check({tag, "_idle_data"}, {20'd0, ser.data_out}, 32'd0);
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_cycles"}, 32'(n), 32'(exp_n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ser.wr_en   = 1'b0;
    ser.wr_idx  = '0;
    ser.wr_data = '0;
    ser.commit  = 1'b0;

    for (int k = 0; k < 10; k++) begin
      fa[k] = 12'(k);
      fx[k] = 12'(k + 20);
      fz[k] = 12'(k + 60);
    end
    fs = {12'h009, 12'h008, 12'h800, 12'h006, 12'h005, 12'h800, 12'h7FF, 12'hFFE, 12'hFFF, 12'h7FF};
    fy = fs;
    fy[0] = 12'h028;
    fy[5] = 12'h02D;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(ser.valid_out), 32'd0);
    check("rst_data", {20'd0, ser.data_out}, 32'd0);
    check("rst_ovf", 32'(ser.ovf_flag), 32'd0);
    check("rst_busy", 32'(ser.busy), 32'd0);
    check("rst_rdy", 32'(ser.in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", 32'(ser.in_ready), 32'd1);

    // Frame A: 16*k -> k, two-cycle commit latency, then the gap
    for (int k = 0; k < 10; k++) wr(4'(k), 20'(16 * k));
    do_commit();
    check("a_lat0_valid", 32'(ser.valid_out), 32'd0);
    check("a_busy", 32'(ser.busy), 32'd1);
    @(negedge clk);
    check("a_lat1_valid", 32'(ser.valid_out), 32'd0);
    @(negedge clk);
    check_burst("a", fa, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("a_gap%0d", i), 32'(ser.valid_out), 32'd0);
    end
    @(negedge clk);
    check("a_idle_busy", 32'(ser.busy), 32'd0);
    check("a_idle_rdy", 32'(ser.in_ready), 32'd1);

    // Frame S (bank 1): saturation, floor rounding, exact boundaries, ignored index
    wr(4'd0, 20'sd32752);
    wr(4'd1, -20'sd1);
    wr(4'd2, -20'sd17);
    wr(4'd3, 20'h7FFFF);
    wr(4'd4, -20'sd32768);
    wr(4'd5, 20'd80);
    wr(4'd6, 20'd96);
    wr(4'd7, 20'h80000);
    wr(4'd8, 20'd128);
    wr(4'd9, 20'd144);
    wr(4'd12, 20'h00100);
    do_commit();
    @(negedge clk);
    @(negedge clk);
    check_burst("sat", fs, 1'b1, 1'b0);
    repeat (10) @(negedge clk);

    // Three frames back-to-back with both banks full in between
    fork
      begin
        for (int k = 0; k < 10; k++) wr(4'(k), 20'(16 * (k + 20)));
        do_commit();
        wr(4'd0, 20'(16 * 40));
        wr(4'd5, 20'(16 * 45));
        do_commit();
        check("b2b_full_rdy", 32'(ser.in_ready), 32'd0);
        ser.wr_en   = 1'b1;
        ser.wr_idx  = 4'd1;
        ser.wr_data = 20'(16 * 99);
        ser.commit  = 1'b1;
        @(negedge clk);
        ser.wr_en   = 1'b0;
        ser.commit  = 1'b0;
        begin
          int n = 0;
          while (ser.in_ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
          end
          check("b2b_rdy_timeout", 32'(n < 30), 32'd1);
        end
        for (int k = 0; k < 10; k++) wr(4'(k), 20'(16 * (k + 60)));
        do_commit();
        check("b2b_z_rdy", 32'(ser.in_ready), 32'd0);
      end
      begin
        wait_valid("x", 40);
        check_burst("x", fx, 1'b0, 1'b1);
        check("x_after_rdy", 32'(ser.in_ready), 32'd1);
        count_idle("xy", 9);
        check_burst("y", fy, 1'b1, 1'b0);
        count_idle("yz", 9);
        check_burst("z", fz, 1'b0, 1'b0);
      end
    join
    repeat (12) @(negedge clk);
    check("b2b_done_busy", 32'(ser.busy), 32'd0);

    // Reset on the fifth cycle of a burst (bank 1 still holds frame Y)
    do_commit();
    wait_valid("r", 10);
    repeat (4) @(negedge clk);
    check("r_mid_valid", 32'(ser.valid_out), 32'd1);
    check("r_mid_data", {20'd0, ser.data_out}, {20'd0, fy[4]});
    rst_n = 1'b0;
    #1;
    check("r_async_valid", 32'(ser.valid_out), 32'd0);
    check("r_async_data", {20'd0, ser.data_out}, 32'd0);
    check("r_async_busy", 32'(ser.busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("r_rdy", 32'(ser.in_ready), 32'd1);
    begin
      int seen = 0;
      for (int i = 0; i < 30; i++) begin
        if (ser.valid_out === 1'b1) seen++;
        @(negedge clk);
      end
      check("r_no_residual", 32'(seen), 32'd0);
    end
    check("r_busy", 32'(ser.busy), 32'd0);

`ifdef FC_SER_BIAS_EN
    bias_we   = 1'b1;
    bias_idx  = 4'd2;
    bias_data = 12'hFFB;
    @(negedge clk);
    bias_idx  = 4'd0;
    bias_data = 12'h7FF;
    @(negedge clk);
    bias_we   = 1'b0;
    wr(4'd2, 20'd48);
    wr(4'd0, 20'sd32752);
    do_commit();
    wait_valid("bias", 10);
    check_burst("bias", {12'h000, 12'h000, 12'h000, 12'h000, 12'h000,
                         12'h000, 12'h000, 12'hFFE, 12'h000, 12'h7FF}, 1'b1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
